// File: rtl/alu_pkg.sv
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared encodings for the ALU issue path: 3-bit ALU opcodes,
//                main-decoder ALUOp codes, R-type Funct values and the
//                default datapath width.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    localparam int DATA_W = 32;

    // Opcodes understood by ALU32Bit
    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_ADD = 3'b010,
        OP_NOP = 3'b011,   // ALU produces zero
        OP_SUB = 3'b110,
        OP_SLT = 3'b111
    } alu_op_e;

    // ALUOp codes from the main decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;  // lw / sw / addi
    localparam logic [1:0] ALUOP_SUB   = 2'b01;  // beq
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;  // decode Funct
    localparam logic [1:0] ALUOP_ORI   = 2'b11;  // ori, zero-extended imm

    // Supported R-type Funct fields
    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

endpackage

`default_nettype wire

// File: rtl/alu_op_decode.sv
// ============================================================================
//  Module      : alu_op_decode
//  Description : Combinational ALUOp/Funct to 3-bit ALU opcode decoder.
//                Unsupported R-type Funct values map to the NOP opcode and
//                raise o_illegal.
//  Ports       : i_alu_op  - 2-bit ALUOp from the main decoder
//                i_funct   - 6-bit R-type function field
//                o_op      - 3-bit ALU opcode
//                o_illegal - unsupported Funct under R-type
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_op_decode
    import alu_pkg::*;
(
    input  logic [1:0] i_alu_op,
    input  logic [5:0] i_funct,
    output logic [2:0] o_op,
    output logic       o_illegal
);

    always_comb begin
        o_op      = OP_NOP;
        o_illegal = 1'b0;
        case (i_alu_op)
            ALUOP_ADD: o_op = OP_ADD;
            ALUOP_SUB: o_op = OP_SUB;
            ALUOP_ORI: o_op = OP_OR;
            ALUOP_RTYPE: begin
                case (i_funct)
                    FUNCT_ADD: o_op = OP_ADD;
                    FUNCT_SUB: o_op = OP_SUB;
                    FUNCT_AND: o_op = OP_AND;
                    FUNCT_OR:  o_op = OP_OR;
                    FUNCT_SLT: o_op = OP_SLT;
                    default: begin
                        o_op      = OP_NOP;
                        o_illegal = 1'b1;
                    end
                endcase
            end
            default: o_op = OP_NOP;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/alu_issue_stage.sv
// ============================================================================
//  Module      : alu_issue_stage
//  Description : Execute-issue stage feeding ALU32Bit. Decodes the ALU
//                opcode, forwards and selects operands, extends the
//                immediate and holds the result in one valid/ready register.
//                Counts consumed instructions (saturating).
//  Ports       : Clk, Rst_n            - clock, synchronous active-low reset
//                InValid / InReady     - upstream handshake
//                ALUOp, Funct, ALUSrc, Imm16, Rs, Rt, RsData, RtData,
//                DestReg, RegWriteIn   - decoded instruction
//                ExFwd*, WbFwd*        - forwarding sources (EX wins)
//                Flush                 - kill held and incoming instruction
//                OutValid / OutReady   - downstream handshake
//                A, B, Op              - registered ALU inputs
//                DestOut, RegWriteOut  - registered writeback info
//                Illegal               - registered unsupported-Funct flag
//                IssueCount            - saturating consumption counter
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int W     = DATA_W,
    parameter int CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             InValid,
    output logic             InReady,
    input  logic [1:0]       ALUOp,
    input  logic [5:0]       Funct,
    input  logic             ALUSrc,
    input  logic [15:0]      Imm16,
    input  logic [4:0]       Rs,
    input  logic [4:0]       Rt,
    input  logic [W-1:0]     RsData,
    input  logic [W-1:0]     RtData,
    input  logic [4:0]       DestReg,
    input  logic             RegWriteIn,
    input  logic             ExFwdValid,
    input  logic [4:0]       ExFwdReg,
    input  logic [W-1:0]     ExFwdData,
    input  logic             WbFwdValid,
    input  logic [4:0]       WbFwdReg,
    input  logic [W-1:0]     WbFwdData,
    input  logic             Flush,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [W-1:0]     A,
    output logic [W-1:0]     B,
    output logic [2:0]       Op,
    output logic [4:0]       DestOut,
    output logic             RegWriteOut,
    output logic             Illegal,
    output logic [CNT_W-1:0] IssueCount
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Combinational decode / operand path
    logic [2:0]   w_dec_op;
    logic         w_dec_illegal;
    logic [W-1:0] w_imm_ext;
    logic [W-1:0] w_rs_val;
    logic [W-1:0] w_rt_val;
    logic [W-1:0] w_b_val;
    logic         w_transfer;
    logic         w_consume;

    // Pipeline register
    logic             out_valid_q,   out_valid_d;
    logic [W-1:0]     a_q,           a_d;
    logic [W-1:0]     b_q,           b_d;
    logic [2:0]       op_q,          op_d;
    logic [4:0]       dest_q,        dest_d;
    logic             reg_write_q,   reg_write_d;
    logic             illegal_q,     illegal_d;
    logic [CNT_W-1:0] count_q,       count_d;

    alu_op_decode u_op_decode (
        .i_alu_op  (ALUOp),
        .i_funct   (Funct),
        .o_op      (w_dec_op),
        .o_illegal (w_dec_illegal)
    );

    // ori uses a zero-extended immediate; every other immediate is signed
    assign w_imm_ext = (ALUOp == ALUOP_ORI) ? {{(W-16){1'b0}}, Imm16}
                                            : {{(W-16){Imm16[15]}}, Imm16};

    // Operand forwarding. r0 is hard-wired, so a producer claiming r0 must
    // never override the register-file value.
    always_comb begin
        w_rs_val = RsData;
        if (Rs != 5'd0) begin
            if (ExFwdValid && (ExFwdReg == Rs))
                w_rs_val = ExFwdData;
            else if (WbFwdValid && (WbFwdReg == Rs))
                w_rs_val = WbFwdData;
        end
    end

    always_comb begin
        w_rt_val = RtData;
        if (Rt != 5'd0) begin
            if (ExFwdValid && (ExFwdReg == Rt))
                w_rt_val = ExFwdData;
            else if (WbFwdValid && (WbFwdReg == Rt))
                w_rt_val = WbFwdData;
        end
    end

    assign w_b_val = ALUSrc ? w_imm_ext : w_rt_val;

    // Flush frees the register, so an incoming instruction is accepted
    // (and then discarded) in the flush cycle.
    assign InReady    = !out_valid_q || OutReady || Flush;
    assign w_transfer = InValid && InReady;
    assign w_consume  = out_valid_q && OutReady;

    always_comb begin
        out_valid_d = out_valid_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        dest_d      = dest_q;
        reg_write_d = reg_write_q;
        illegal_d   = illegal_q;
        count_d     = count_q;

        // Flush dominates both load and hold
        if (Flush) begin
            out_valid_d = 1'b0;
            reg_write_d = 1'b0;
        end else if (w_transfer) begin
            out_valid_d = 1'b1;
            a_d         = w_rs_val;
            b_d         = w_b_val;
            op_d        = w_dec_op;
            dest_d      = DestReg;
            reg_write_d = RegWriteIn && !w_dec_illegal;
            illegal_d   = w_dec_illegal;
        end else if (w_consume) begin
            out_valid_d = 1'b0;
        end

        if (w_consume && !Flush && (count_q != CNT_MAX))
            count_d = count_q + CNT_ONE;
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            out_valid_q <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= 3'b000;
            dest_q      <= 5'd0;
            reg_write_q <= 1'b0;
            illegal_q   <= 1'b0;
            count_q     <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            dest_q      <= dest_d;
            reg_write_q <= reg_write_d;
            illegal_q   <= illegal_d;
            count_q     <= count_d;
        end
    end

    assign OutValid    = out_valid_q;
    assign A           = a_q;
    assign B           = b_q;
    assign Op          = op_q;
    assign DestOut     = dest_q;
    assign RegWriteOut = reg_write_q;
    assign Illegal     = illegal_q;
    assign IssueCount  = count_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
// ============================================================================
//  Module      : tb_alu_issue_stage
//  Description : Self-checking bench for alu_issue_stage: table of decoded
//                instructions with hand-derived expected outputs, plus
//                sequences for stall, flush, saturation and reset.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_issue_stage;

    localparam int W     = 32;
    localparam int CNT_W = 16;
    localparam int NVEC  = 12;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       alu_op;
    logic [5:0]       funct;
    logic             alu_src;
    logic [15:0]      imm16;
    logic [4:0]       rs;
    logic [4:0]       rt;
    logic [W-1:0]     rs_data;
    logic [W-1:0]     rt_data;
    logic [4:0]       dest_reg;
    logic             reg_write_in;
    logic             ex_v;
    logic [4:0]       ex_r;
    logic [W-1:0]     ex_d;
    logic             wb_v;
    logic [4:0]       wb_r;
    logic [W-1:0]     wb_d;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     a_out;
    logic [W-1:0]     b_out;
    logic [2:0]       op_out;
    logic [4:0]       dest_out;
    logic             rw_out;
    logic             ill_out;
    logic [CNT_W-1:0] issue_count;

    always #5 clk = ~clk;

    alu_issue_stage #(.W(W), .CNT_W(CNT_W)) dut (
        .Clk         (clk),
        .Rst_n       (rst_n),
        .InValid     (in_valid),
        .InReady     (in_ready),
        .ALUOp       (alu_op),
        .Funct       (funct),
        .ALUSrc      (alu_src),
        .Imm16       (imm16),
        .Rs          (rs),
        .Rt          (rt),
        .RsData      (rs_data),
        .RtData      (rt_data),
        .DestReg     (dest_reg),
        .RegWriteIn  (reg_write_in),
        .ExFwdValid  (ex_v),
        .ExFwdReg    (ex_r),
        .ExFwdData   (ex_d),
        .WbFwdValid  (wb_v),
        .WbFwdReg    (wb_r),
        .WbFwdData   (wb_d),
        .Flush       (flush),
        .OutValid    (out_valid),
        .OutReady    (out_ready),
        .A           (a_out),
        .B           (b_out),
        .Op          (op_out),
        .DestOut     (dest_out),
        .RegWriteOut (rw_out),
        .Illegal     (ill_out),
        .IssueCount  (issue_count)
    );

    typedef struct {
        logic [1:0]  aop;
        logic [5:0]  f;
        logic        src;
        logic [15:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [31:0] rsd;
        logic [31:0] rtd;
        logic [4:0]  dest;
        logic        rwin;
        logic        exv;
        logic [4:0]  exr;
        logic [31:0] exd;
        logic        wbv;
        logic [4:0]  wbr;
        logic [31:0] wbd;
        logic [31:0] ea;
        logic [31:0] eb;
        logic [2:0]  eop;
        logic        erw;
        logic        eill;
    } vec_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic [4:0]  dest;
        logic        rw;
        logic        ill;
    } exp_t;

    vec_t vt [NVEC];
    exp_t sb [$];
    exp_t held;
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic vec_t mk(
        logic [1:0] aop, logic [5:0] f, logic src, logic [15:0] imm,
        logic [4:0] rs_i, logic [4:0] rt_i, logic [31:0] rsd, logic [31:0] rtd,
        logic [4:0] dest, logic rwin,
        logic exv, logic [4:0] exr, logic [31:0] exd,
        logic wbv, logic [4:0] wbr, logic [31:0] wbd,
        logic [31:0] ea, logic [31:0] eb, logic [2:0] eop, logic erw, logic eill);
        vec_t v;
        v.aop = aop; v.f = f; v.src = src; v.imm = imm; v.rs = rs_i; v.rt = rt_i;
        v.rsd = rsd; v.rtd = rtd; v.dest = dest; v.rwin = rwin;
        v.exv = exv; v.exr = exr; v.exd = exd; v.wbv = wbv; v.wbr = wbr; v.wbd = wbd;
        v.ea = ea; v.eb = eb; v.eop = eop; v.erw = erw; v.eill = eill;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        in_valid = 1'b1;
        alu_op = v.aop; funct = v.f; alu_src = v.src; imm16 = v.imm;
        rs = v.rs; rt = v.rt; rs_data = v.rsd; rt_data = v.rtd;
        dest_reg = v.dest; reg_write_in = v.rwin;
        ex_v = v.exv; ex_r = v.exr; ex_d = v.exd;
        wb_v = v.wbv; wb_r = v.wbr; wb_d = v.wbd;
    endtask

    task automatic push(input vec_t v);
        exp_t e;
        e.a = v.ea; e.b = v.eb; e.op = v.eop; e.dest = v.dest; e.rw = v.erw; e.ill = v.eill;
        sb.push_back(e);
    endtask

    task automatic cmp_held(input string tag, input exp_t e);
        chk({tag, " valid"}, out_valid, 1'b1);
        chk({tag, " A"}, a_out, e.a);
        chk({tag, " B"}, b_out, e.b);
        chk({tag, " Op"}, op_out, e.op);
        chk({tag, " Dest"}, dest_out, e.dest);
        chk({tag, " RegWrite"}, rw_out, e.rw);
        chk({tag, " Illegal"}, ill_out, e.ill);
    endtask

    task automatic check_out(input string tag, output exp_t e);
        e = '{default: '0};
        if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: scoreboard empty when output expected", tag);
        end else begin
            e = sb.pop_front();
            cmp_held(tag, e);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, " valid"}, out_valid, 1'b0);
        chk({tag, " A"}, a_out, 32'h0);
        chk({tag, " B"}, b_out, 32'h0);
        chk({tag, " Op"}, op_out, 3'b000);
        chk({tag, " Dest"}, dest_out, 5'd0);
        chk({tag, " RegWrite"}, rw_out, 1'b0);
        chk({tag, " Illegal"}, ill_out, 1'b0);
        chk({tag, " count"}, issue_count, 16'h0);
    endtask

    initial begin
        //           aop   funct     src imm       rs rt rsd           rtd           dst rw exv exr exd         wbv wbr wbd         ea            eb            op     rw ill
        vt[0]  = mk(2'b10, 6'b100100, 0, 16'h0000, 1, 2, 32'ha5a5a5a5, 32'h5a5a5a5a, 3, 1, 0, 0, 32'h0,       0, 0, 32'h0,       32'ha5a5a5a5, 32'h5a5a5a5a, 3'b000, 1, 0);
        vt[1]  = mk(2'b00, 6'b000000, 1, 16'h8000, 4, 6, 32'h00000010, 32'h00000020, 6, 1, 0, 0, 32'h0,       0, 0, 32'h0,       32'h00000010, 32'hffff8000, 3'b010, 1, 0);
        vt[2]  = mk(2'b11, 6'b000000, 1, 16'h8000, 4, 6, 32'h00000010, 32'h00000020, 6, 1, 0, 0, 32'h0,       0, 0, 32'h0,       32'h00000010, 32'h00008000, 3'b001, 1, 0);
        vt[3]  = mk(2'b10, 6'b100000, 0, 16'h0000, 5, 9, 32'h00000055, 32'h00000099, 7, 1, 1, 5, 32'h11,      1, 5, 32'h22,      32'h00000011, 32'h00000099, 3'b010, 1, 0);
        vt[4]  = mk(2'b10, 6'b100010, 0, 16'h0000, 0, 0, 32'h00001234, 32'h00005678, 8, 1, 1, 0, 32'h33,      1, 0, 32'h44,      32'h00001234, 32'h00005678, 3'b110, 1, 0);
        vt[5]  = mk(2'b10, 6'b100101, 0, 16'h0000, 8, 7, 32'h000000aa, 32'h000000bb, 9, 1, 1, 9, 32'h66,      1, 7, 32'h77,      32'h000000aa, 32'h00000077, 3'b001, 1, 0);
        vt[6]  = mk(2'b10, 6'b101010, 0, 16'h0000, 3, 4, 32'h00000001, 32'h00000002, 10, 1, 1, 3, 32'h300,    1, 4, 32'h400,     32'h00000300, 32'h00000400, 3'b111, 1, 0);
        vt[7]  = mk(2'b01, 6'b000000, 0, 16'h0004, 1, 2, 32'h00000001, 32'h00000001, 0, 0, 0, 0, 32'h0,       0, 0, 32'h0,       32'h00000001, 32'h00000001, 3'b110, 0, 0);
        vt[8]  = mk(2'b10, 6'b000111, 0, 16'h0000, 1, 2, 32'h00000007, 32'h00000008, 11, 1, 0, 0, 32'h0,      0, 0, 32'h0,       32'h00000007, 32'h00000008, 3'b011, 0, 1);
        vt[9]  = mk(2'b00, 6'b000000, 1, 16'hfffc, 1, 2, 32'h00000100, 32'h00000200, 2, 1, 1, 2, 32'hdead,    0, 0, 32'h0,       32'h00000100, 32'hfffffffc, 3'b010, 1, 0);
        vt[10] = mk(2'b00, 6'b000000, 1, 16'h7fff, 10, 2, 32'h00000001, 32'h00000002, 12, 1, 1, 10, 32'hcafe, 1, 10, 32'hbeef,  32'h0000cafe, 32'h00007fff, 3'b010, 1, 0);
        vt[11] = mk(2'b11, 6'b000111, 1, 16'hffff, 1, 2, 32'h00000003, 32'h00000004, 13, 1, 0, 0, 32'h0,      0, 0, 32'h0,       32'h00000003, 32'h0000ffff, 3'b001, 1, 0);

        // Reset with a live instruction offered: reset must win
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
        drive(vt[0]);
        repeat (2) @(posedge clk);
        #1;
        check_reset("reset");
        chk("reset InReady", in_ready, 1'b1);

        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b0;

        // Table: one instruction per cycle at full throughput
        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            drive(vt[i]);
            push(vt[i]);
            @(posedge clk);
            #1;
            check_out($sformatf("vec%0d", i), held);
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("drain valid", out_valid, 1'b0);
        chk("drain count", issue_count, 16'd12);

        // Stall: hold S1 for 3 cycles while S2 waits
        @(negedge clk);
        drive(vt[3]);
        push(vt[3]);
        @(posedge clk);
        #1;
        check_out("stall load", held);
        @(negedge clk);
        out_ready = 1'b0;
        drive(vt[6]);
        push(vt[6]);
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            rs_data = $urandom;
            ex_d    = $urandom;
            #1;
            chk($sformatf("stall%0d InReady", k), in_ready, 1'b0);
            @(posedge clk);
            #1;
            cmp_held($sformatf("stall%0d", k), held);
            chk($sformatf("stall%0d count", k), issue_count, 16'd12);
        end
        @(negedge clk);
        drive(vt[6]);
        out_ready = 1'b1;
        #1;
        chk("release InReady", in_ready, 1'b1);
        @(posedge clk);
        #1;
        check_out("release", held);
        chk("release count", issue_count, 16'd13);

        // Flush during stall with a new instruction offered
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        @(posedge clk);
        #1;
        cmp_held("pre-flush hold", held);
        @(negedge clk);
        flush = 1'b1;
        drive(vt[1]);
        #1;
        chk("flush InReady", in_ready, 1'b1);
        @(posedge clk);
        #1;
        chk("flush valid", out_valid, 1'b0);
        chk("flush RegWrite", rw_out, 1'b0);
        chk("flush count", issue_count, 16'd13);
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("flush dropped", out_valid, 1'b0);

        // Flush in a consumption cycle must not count
        @(negedge clk);
        out_ready = 1'b1;
        drive(vt[2]);
        push(vt[2]);
        @(posedge clk);
        #1;
        check_out("pre-flush2", held);
        @(negedge clk);
        in_valid = 1'b0;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        chk("flush2 valid", out_valid, 1'b0);
        chk("flush2 count", issue_count, 16'd13);
        @(negedge clk);
        flush = 1'b0;

        // Saturate the counter with back-to-back traffic
        drive(vt[0]);
        repeat (65540) @(posedge clk);
        #1;
        chk("saturated count", issue_count, 16'hffff);
        chk("saturated valid", out_valid, 1'b1);
        @(posedge clk);
        #1;
        chk("saturated no wrap", issue_count, 16'hffff);

        // Reset in the middle of a stall
        @(negedge clk);
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        chk("pre-reset hold", out_valid, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_reset("mid-stall reset");
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("post-reset valid", out_valid, 1'b0);
        chk("scoreboard drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
